alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of operands and results.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  2  bit i = requester i presents an operation.
REQ-005 SHALL have port req_ready  output  2  bit i = requester i's operation accepted this cycle (valid&ready = grant).
REQ-006 SHALL have port req_a  input  2*XLEN  operand A; requester i in bits [i*XLEN +: XLEN].
REQ-007 SHALL have port req_b  input  2*XLEN  operand B; same packing.
REQ-008 SHALL have port req_op  input  8  4-bit ALU opcode; requester i in bits [i*4 +: 4].
REQ-009 SHALL have port rsp_valid  output  1  registered response available.
REQ-010 SHALL have port rsp_ready  input  1  consumer accepts response this cycle.
REQ-011 SHALL have port rsp_id  output  1  requester index owning the response.
REQ-012 SHALL have port rsp_result  output  XLEN  ALU result.
REQ-013 SHALL have port rsp_zero  output  1  1 when rsp_result is all zeros and rsp_err is 0.
REQ-014 SHALL have port rsp_err  output  1  1 when the granted opcode was illegal (9..15).

Function
REQ-015 SHALL share one ALU instance between two requesters, at most one grant per cycle.
REQ-016 SHALL define slot_free = !rsp_valid || rsp_ready; no grant when slot_free is 0.
REQ-017 SHALL, with one requester valid and slot_free, grant that requester.
REQ-018 SHALL, with both valid and slot_free, grant the requester not granted last (round-robin via last_grant register).
REQ-019 SHALL update last_grant only on a grant.
REQ-020 SHALL drive req_ready combinationally, one-hot or zero, never to an unrequesting port... req_ready[i] may depend on req_valid.
REQ-021 SHALL register result, zero, id and err at the grant edge; rsp_valid rises the cycle after grant (latency 1).
REQ-022 SHALL hold rsp_* stable while rsp_valid && !rsp_ready.
REQ-023 SHALL, when rsp_ready and a new grant coincide, replace the response back-to-back (throughput 1 op/cycle).
REQ-024 SHALL, when rsp_ready and no grant, clear rsp_valid next cycle.
REQ-025 SHALL compute opcodes 0..8: ADD, SUB, AND, OR, XOR, SLT (unsigned compare), SRL, SRA, SLL; shifts use b[4:0].
REQ-026 SHALL, for illegal opcodes, register rsp_result=0, rsp_err=1, rsp_zero=0; never propagate X.
REQ-027 SHALL implement states IDLE (rsp_valid=0) and HOLD (rsp_valid=1): IDLE->HOLD on grant; HOLD->IDLE on rsp_ready without grant; otherwise stay.
REQ-028 SHALL ignore req_a/req_b/req_op of non-granted ports.

Reset
REQ-029 SHALL, when reset is high at a clock edge, set state IDLE, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_err=0, last_grant=1 (port 0 wins first tie).
REQ-030 SHALL drive req_ready=0 during any cycle reset is high.
REQ-031 SHALL discard any held response on reset mid-operation; no grant is issued in the reset cycle.

Structure
REQ-032 SHALL take opcode enum alu_op_e (ADD=0..SLL=8) and constant ALU_OP_LAST=8 from shared package alu_pkg.
REQ-033 SHALL instantiate the existing alu module once as sole sub-module; operand mux and illegal-op masking in alu_arbiter.
REQ-034 SHALL contain no latches; one always_ff for state, always_comb for arbitration.

Verification
REQ-035 SHALL cover: reset, port0 valid, a=5,b=3,op=SUB -> next cycle rsp_valid=1, id=0, result=2, zero=0.
REQ-036 SHALL cover: both valid after reset, rsp_ready=1 -> grants port0, port1, port0 on consecutive cycles; responses 1/cycle.
REQ-037 SHALL cover: rsp_ready=0 with response held -> req_ready=00, rsp_* stable 5 cycles; rsp_ready=1 -> same-cycle next grant.
REQ-038 SHALL cover: port1 op=4'hC -> rsp_id=1, result=0, err=1, zero=0.
REQ-039 SHALL cover: a=32'h8000_0000, b=4, op=SRA -> result=32'hF800_0000; op=SUB a=b=7 -> zero=1.
REQ-040 SHALL cover: reset asserted while HOLD -> next cycle rsp_valid=0, then tie grants port0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode definitions for the ALU and its arbiter front end.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    AND = 4'd2,
    OR  = 4'd3,
    XOR = 4'd4,
    SLT = 4'd5,
    SRL = 4'd6,
    SRA = 4'd7,
    SLL = 4'd8
  } alu_op_e;

  localparam int unsigned ALU_OP_LAST = 8;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StHold = 1'b1
  } arb_state_e;

  function automatic logic op_is_legal(input logic [3:0] op);
    return op <= 4'(ALU_OP_LAST);
  endfunction

endpackage

// File: rtl/alu.sv
// Purely combinational ALU; undefined opcodes produce zero.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      op,
  output logic [XLEN-1:0] result
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    case (alu_op_e'(op))
      ADD:     result = a + b;
      SUB:     result = a - b;
      AND:     result = a & b;
      OR:      result = a | b;
      XOR:     result = a ^ b;
      SLT:     result = {{(XLEN-1){1'b0}}, (a < b)};
      SRL:     result = a >> shamt;
      SRA:     result = $signed(a) >>> shamt;
      SLL:     result = a << shamt;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one ALU, with a single-entry
// registered response slot that refills back-to-back when drained.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [2*XLEN-1:0] req_a,
  input  logic [2*XLEN-1:0] req_b,
  input  logic [7:0]        req_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [XLEN-1:0]   rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err
);

  arb_state_e      state_q;
  logic            last_grant_q;
  logic            rsp_id_q;
  logic [XLEN-1:0] rsp_result_q;
  logic            rsp_zero_q;
  logic            rsp_err_q;

  logic            slot_free;
  logic [1:0]      grant;
  logic            sel;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [3:0]      op_sel;
  logic [XLEN-1:0] alu_result;
  logic            illegal;
  logic [XLEN-1:0] result_masked;

  assign rsp_valid = (state_q == StHold);
  assign slot_free = !rsp_valid || rsp_ready;

  // last_grant_q == 1 means port 1 won most recently, so port 0 wins a tie.
  always_comb begin
    grant = 2'b00;
    if (!reset && slot_free) begin
      if (req_valid == 2'b11) begin
        grant = last_grant_q ? 2'b01 : 2'b10;
      end else begin
        grant = req_valid;
      end
    end
  end

  assign req_ready = grant;
  assign sel       = grant[1];
  assign op_a      = sel ? req_a[2*XLEN-1:XLEN] : req_a[XLEN-1:0];
  assign op_b      = sel ? req_b[2*XLEN-1:XLEN] : req_b[XLEN-1:0];
  assign op_sel    = sel ? req_op[7:4] : req_op[3:0];

  alu #(
    .XLEN(XLEN)
  ) u_alu (
    .a      (op_a),
    .b      (op_b),
    .op     (op_sel),
    .result (alu_result)
  );

  assign illegal       = !op_is_legal(op_sel);
  assign result_masked = illegal ? '0 : alu_result;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else if (grant != 2'b00) begin
      state_q      <= StHold;
      last_grant_q <= sel;
      rsp_id_q     <= sel;
      rsp_result_q <= result_masked;
      rsp_zero_q   <= !illegal && (result_masked == '0);
      rsp_err_q    <= illegal;
    end else if (rsp_ready) begin
      state_q <= StIdle;
    end
  end

  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench: directed sequences, an opcode vector table, and random
// traffic, all compared against a rule-level reference model.
module tb_alu_arbiter;

  localparam int unsigned XLEN = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [2*XLEN-1:0] req_a;
  logic [2*XLEN-1:0] req_b;
  logic [7:0]        req_op;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [XLEN-1:0]   rsp_result;
  logic              rsp_zero;
  logic              rsp_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic        m_valid;
  logic        m_id;
  logic [31:0] m_res;
  logic        m_zero;
  logic        m_err;
  logic        m_last;

  always #5 clk = ~clk;

  alu_arbiter #(
    .XLEN(XLEN)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    int unsigned s;
    logic [31:0] r;
    s = b % 32;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = (a < b) ? 32'd1 : 32'd0;
      4'd6: r = a >> s;
      4'd7: begin
        r = a >> s;
        if (a[31]) r = r | ~(32'hFFFF_FFFF >> s);
      end
      4'd8: r = a << s;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // One clock cycle: drive, check arbitration, clock, update model, check response.
  task automatic cycle(input logic rst, input logic [1:0] v, input logic [63:0] a,
                       input logic [63:0] b, input logic [7:0] op, input logic rr);
    logic [1:0]  g;
    logic        p;
    logic [31:0] pa, pb;
    logic [3:0]  po;
    reset = rst; req_valid = v; req_a = a; req_b = b; req_op = op; rsp_ready = rr;
    #2;
    g = 2'b00;
    if (!rst && (!m_valid || rr)) begin
      if (v == 2'b11) g = m_last ? 2'b01 : 2'b10;
      else g = v;
    end
    check("req_ready", {62'd0, req_ready}, {62'd0, g});
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_id = 0; m_res = 0; m_zero = 0; m_err = 0; m_last = 1;
    end else if (g != 2'b00) begin
      p = g[1];
      pa = p ? a[63:32] : a[31:0];
      pb = p ? b[63:32] : b[31:0];
      po = p ? op[7:4] : op[3:0];
      m_valid = 1;
      m_id    = p;
      m_last  = p;
      m_err   = (po > 4'd8);
      m_res   = alu_ref(pa, pb, po);
      m_zero  = !m_err && (m_res == 0);
    end else if (rr) begin
      m_valid = 0;
    end
    #1;
    check("rsp_valid", {63'd0, rsp_valid}, {63'd0, m_valid});
    if (m_valid || rst) begin
      check("rsp_id", {63'd0, rsp_id}, {63'd0, m_id});
      check("rsp_result", {32'd0, rsp_result}, {32'd0, m_res});
      check("rsp_zero", {63'd0, rsp_zero}, {63'd0, m_zero});
      check("rsp_err", {63'd0, rsp_err}, {63'd0, m_err});
    end
  endtask

  typedef struct {
    logic        port;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] res;
    logic        err;
    logic        zero;
  } vec_t;

  vec_t vecs[13];
  logic [31:0] held;

  initial begin
    vecs[0]  = '{0, 32'd5,          32'd3,          4'd0, 32'd8,          0, 0};
    vecs[1]  = '{1, 32'd5,          32'd3,          4'd1, 32'd2,          0, 0};
    vecs[2]  = '{0, 32'd7,          32'd7,          4'd1, 32'd0,          0, 1};
    vecs[3]  = '{1, 32'hF0F0_F0F0,  32'hFF00_FF00,  4'd2, 32'hF000_F000,  0, 0};
    vecs[4]  = '{0, 32'h0000_00F0,  32'h0000_000F,  4'd3, 32'h0000_00FF,  0, 0};
    vecs[5]  = '{1, 32'h0000_FFFF,  32'h0000_00FF,  4'd4, 32'h0000_FF00,  0, 0};
    vecs[6]  = '{0, 32'd1,          32'hFFFF_FFFF,  4'd5, 32'd1,          0, 0};
    vecs[7]  = '{1, 32'hFFFF_FFFF,  32'd1,          4'd5, 32'd0,          0, 1};
    vecs[8]  = '{0, 32'h8000_0000,  32'd4,          4'd6, 32'h0800_0000,  0, 0};
    vecs[9]  = '{1, 32'h8000_0000,  32'd4,          4'd7, 32'hF800_0000,  0, 0};
    vecs[10] = '{0, 32'd1,          32'h0000_0023,  4'd8, 32'd8,          0, 0};
    vecs[11] = '{1, 32'h1234_5678,  32'h9ABC_DEF0,  4'hC, 32'd0,          1, 0};
    vecs[12] = '{0, 32'd0,          32'd0,          4'h9, 32'd0,          1, 0};

    m_valid = 0; m_id = 0; m_res = 0; m_zero = 0; m_err = 0; m_last = 1;

    // Reset with both requesting: no grant, outputs cleared.
    cycle(1, 2'b11, '1, '1, 8'h00, 1);
    cycle(1, 2'b11, '1, '1, 8'h00, 1);

    // Port 0: 5 - 3 = 2 with one-cycle latency.
    cycle(0, 2'b01, {32'd0, 32'd5}, {32'd0, 32'd3}, 8'h01, 1);
    check("sub_valid", {63'd0, rsp_valid}, 64'd1);
    check("sub_id", {63'd0, rsp_id}, 64'd0);
    check("sub_result", {32'd0, rsp_result}, 64'd2);
    check("sub_zero", {63'd0, rsp_zero}, 64'd0);

    // Tie after reset: 0, 1, 0 on consecutive cycles.
    cycle(1, 2'b00, '0, '0, 8'h00, 1);
    cycle(0, 2'b11, {32'd10, 32'd1}, {32'd2, 32'd1}, 8'h00, 1);
    check("rr0_id", {63'd0, rsp_id}, 64'd0);
    check("rr0_result", {32'd0, rsp_result}, 64'd2);
    cycle(0, 2'b11, {32'd10, 32'd1}, {32'd2, 32'd1}, 8'h00, 1);
    check("rr1_id", {63'd0, rsp_id}, 64'd1);
    check("rr1_result", {32'd0, rsp_result}, 64'd12);
    cycle(0, 2'b11, {32'd10, 32'd1}, {32'd2, 32'd1}, 8'h00, 1);
    check("rr2_id", {63'd0, rsp_id}, 64'd0);

    // Backpressure: response held stable, no grants; release regrants same cycle.
    held = rsp_result;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 2'b11, {32'd9, 32'd9}, {32'd9, 32'd9}, 8'h11, 0);
      check("hold_ready", {62'd0, req_ready}, 64'd0);
      check("hold_result", {32'd0, rsp_result}, {32'd0, held});
    end
    cycle(0, 2'b11, {32'd9, 32'd9}, {32'd9, 32'd9}, 8'h11, 1);
    check("release_id", {63'd0, rsp_id}, 64'd1);
    check("release_zero", {63'd0, rsp_zero}, 64'd1);
    cycle(0, 2'b00, '0, '0, 8'h00, 1);
    check("drain_valid", {63'd0, rsp_valid}, 64'd0);

    // Opcode vector table.
    for (int i = 0; i < 13; i++) begin
      cycle(0, vecs[i].port ? 2'b10 : 2'b01, {vecs[i].a, vecs[i].a}, {vecs[i].b, vecs[i].b},
            {vecs[i].op, vecs[i].op}, 1);
      check($sformatf("vec%0d_id", i), {63'd0, rsp_id}, {63'd0, vecs[i].port});
      check($sformatf("vec%0d_result", i), {32'd0, rsp_result}, {32'd0, vecs[i].res});
      check($sformatf("vec%0d_err", i), {63'd0, rsp_err}, {63'd0, vecs[i].err});
      check($sformatf("vec%0d_zero", i), {63'd0, rsp_zero}, {63'd0, vecs[i].zero});
    end

    // Reset while holding discards the response; next tie goes to port 0.
    cycle(0, 2'b10, {32'd3, 32'd0}, {32'd4, 32'd0}, 8'h00, 0);
    cycle(0, 2'b00, '0, '0, 8'h00, 0);
    cycle(1, 2'b11, '0, '0, 8'h00, 0);
    check("rst_hold_valid", {63'd0, rsp_valid}, 64'd0);
    cycle(0, 2'b11, {32'd1, 32'd2}, {32'd1, 32'd2}, 8'h00, 1);
    check("rst_tie_id", {63'd0, rsp_id}, 64'd0);
    check("rst_tie_result", {32'd0, rsp_result}, 64'd4);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 49) == 0), 2'($urandom_range(0, 3)),
            {$urandom, $urandom}, {$urandom, $urandom},
            {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))},
            ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
